// File: rtl/udp_rx_pkg.sv
// Shared definitions for the UDP receive stage: system-wide defines, FSM states and
// the ones-complement add helper used by the checksum logic.
`ifndef FPGA_DATA_WIDTH
`define FPGA_DATA_WIDTH 8
`endif
`ifndef FPGA_IP
`define FPGA_IP 32'h0A00_0002
`endif
`ifndef FPGA_UDP_PORT
`define FPGA_UDP_PORT 16'd5000
`endif

package udp_rx_pkg;
    localparam int          DATA_W           = `FPGA_DATA_WIDTH;
    localparam logic [31:0] LOCAL_IP         = `FPGA_IP;
    localparam logic [7:0]  UDP_PROTO        = 8'h11;
    localparam logic [15:0] UDP_HDR_LEN      = 16'd8;
    localparam logic [15:0] UDP_PORT_DEFAULT = `FPGA_UDP_PORT;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_VERDICT = 3'd3,
        ST_DISCARD = 3'd4
    } udp_state_t;

    // 17-bit add with the carry wrapped back into bit 0 (ones-complement addition).
    function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction
endpackage

// File: rtl/udp_rx_if.sv
// Payload-side bundle from the UDP receive stage to the application parser.
interface udp_rx_if;
    import udp_rx_pkg::*;

    logic [31:0]       src_ip;
    logic [15:0]       src_port;
    logic [15:0]       payload_len;
    logic              payload_valid;
    logic              payload_sop;
    logic              payload_eop;
    logic [DATA_W-1:0] payload_data;
    logic              payload_done;
    logic              payload_err;

    modport master (
        output src_ip, src_port, payload_len, payload_valid, payload_sop,
               payload_eop, payload_data, payload_done, payload_err
    );

    modport slave (
        input  src_ip, src_port, payload_len, payload_valid, payload_sop,
               payload_eop, payload_data, payload_done, payload_err
    );
endinterface

// File: rtl/udp_rx_csum_acc.sv
// Ones-complement checksum accumulator: pairs bytes into big-endian words, accepts an
// extra word per cycle, and reports pass with any pending odd byte padded by 8'h00.
module udp_csum_acc
    import udp_rx_pkg::*;
(
    input  logic        i_sys_clk,
    input  logic        i_rstn,
    input  logic        i_clr,
    input  logic [15:0] i_seed,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte,
    input  logic        i_word_vld,
    input  logic [15:0] i_word,
    output logic        o_pass
);
    logic [15:0] sum_r;
    logic [15:0] pair_s;
    logic [15:0] sum_s;
    logic [15:0] final_s;
    logic [7:0]  hi_r;
    logic        odd_r;

    // Next running sum and the padded final sum used for the pass flag.
    always_comb begin
        pair_s  = sum_r;
        sum_s   = sum_r;
        final_s = sum_r;
        if (i_clr) begin
            pair_s = i_seed;
        end else if (i_byte_vld && odd_r) begin
            pair_s = oc_add(sum_r, {hi_r, i_byte});
        end else begin
            pair_s = sum_r;
        end
        sum_s   = i_word_vld ? oc_add(pair_s, i_word) : pair_s;
        final_s = odd_r ? oc_add(sum_r, {hi_r, 8'h00}) : sum_r;
        o_pass  = (final_s == 16'hFFFF);
    end

    // Sum register and high-byte holding register for word pairing.
    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sum_r <= 16'h0000;
            hi_r  <= 8'h00;
            odd_r <= 1'b0;
        end else begin
            sum_r <= sum_s;
            if (i_clr) begin
                hi_r  <= i_byte;
                odd_r <= i_byte_vld;
            end else if (i_byte_vld) begin
                if (!odd_r) begin
                    hi_r <= i_byte;
                end
                odd_r <= !odd_r;
            end
        end
    end
endmodule

// File: rtl/udp_rx.sv
// UDP receive stage: parses and filters the 8-byte header, verifies the checksum and
// forwards payload bytes with sop/eop framing followed by a done/err verdict.
module udp_rx
    import udp_rx_pkg::*;
#(
    parameter logic [15:0] LOCAL_PORT  = UDP_PORT_DEFAULT,
    parameter bit          CHECKSUM_EN = 1'b1
) (
    input  logic              i_sys_clk,
    input  logic              i_rstn,
    input  logic              i_new_segment,
    input  logic              i_drop_segment,
    input  logic [31:0]       i_src_ip,
    input  logic [15:0]       i_segment_len_b,
    input  logic [7:0]        i_segment_type,
    input  logic [DATA_W-1:0] i_segment_data,
    output logic              o_udp_drop,
    udp_rx_if.master          pl
);
    udp_state_t        state_r, state_s;
    logic [2:0]        hdr_cnt_r;
    logic [15:0]       pay_cnt_r, payload_len_r, udp_len_r, csum_rx_r, src_port_r;
    logic [31:0]       src_ip_r;
    logic [DATA_W-1:0] prev_byte_r, data_r;
    logic [15:0]       word_s, csum_seed_s;
    logic              start_udp_s, hdr_byte_s, pay_byte_s, hdr_reject_s, last_pay_s;
    logic              csum_word_vld_s, csum_pass_s;
    logic              udp_drop_s, valid_s, sop_s, eop_s, done_s, err_s;
    logic              udp_drop_r, valid_r, sop_r, eop_r, done_r, err_r;

    // Decode of the byte on the bus: header filtering and checksum feed controls.
    always_comb begin
        word_s       = {prev_byte_r, i_segment_data};
        start_udp_s  = (state_r == ST_IDLE) && i_new_segment && (i_segment_type == UDP_PROTO);
        hdr_byte_s   = (state_r == ST_HEADER) && i_new_segment && !i_drop_segment;
        pay_byte_s   = (state_r == ST_PAYLOAD) && i_new_segment && !i_drop_segment;
        hdr_reject_s = 1'b0;
        if (hdr_byte_s && (hdr_cnt_r == 3'd3)) begin
            hdr_reject_s = (word_s != LOCAL_PORT);
        end else if (hdr_byte_s && (hdr_cnt_r == 3'd5)) begin
            hdr_reject_s = (word_s < UDP_HDR_LEN) || (word_s > i_segment_len_b);
        end else begin
            hdr_reject_s = 1'b0;
        end
        last_pay_s      = (pay_cnt_r == (payload_len_r - 16'd1));
        // The header length field and the pseudo-header length are the same value.
        csum_word_vld_s = hdr_byte_s && (hdr_cnt_r == 3'd6);
        csum_seed_s     = oc_add(oc_add(oc_add(oc_add(i_src_ip[31:16], i_src_ip[15:0]),
                                 LOCAL_IP[31:16]), LOCAL_IP[15:0]), {8'h00, UDP_PROTO});
    end

    udp_csum_acc u_csum (
        .i_sys_clk  (i_sys_clk),
        .i_rstn     (i_rstn),
        .i_clr      (start_udp_s),
        .i_seed     (csum_seed_s),
        .i_byte_vld (start_udp_s || hdr_byte_s || pay_byte_s),
        .i_byte     (i_segment_data),
        .i_word_vld (csum_word_vld_s),
        .i_word     (udp_len_r),
        .o_pass     (csum_pass_s)
    );

    // State register.
    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort paths leave through DISCARD while the segment still streams.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_new_segment) begin
                    state_s = (i_segment_type == UDP_PROTO) ? ST_HEADER : ST_DISCARD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (!i_new_segment) begin
                    state_s = ST_IDLE;
                end else if (i_drop_segment || hdr_reject_s) begin
                    state_s = ST_DISCARD;
                end else if (hdr_cnt_r == 3'd7) begin
                    state_s = (udp_len_r == UDP_HDR_LEN) ? ST_VERDICT : ST_PAYLOAD;
                end else begin
                    state_s = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                if (!i_new_segment) begin
                    state_s = ST_IDLE;
                end else if (i_drop_segment) begin
                    state_s = ST_DISCARD;
                end else if (last_pay_s) begin
                    state_s = ST_VERDICT;
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end
            ST_VERDICT: state_s = i_new_segment ? ST_DISCARD : ST_IDLE;
            ST_DISCARD: state_s = i_new_segment ? ST_DISCARD : ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // Output decode; drop or truncation during payload yields an immediate failed verdict.
    always_comb begin
        udp_drop_s = hdr_reject_s;
        valid_s    = pay_byte_s;
        sop_s      = pay_byte_s && (pay_cnt_r == 16'd0);
        eop_s      = pay_byte_s && last_pay_s;
        done_s     = 1'b0;
        err_s      = 1'b0;
        case (state_r)
            ST_PAYLOAD: begin
                if (!pay_byte_s) begin
                    done_s = 1'b1;
                    err_s  = 1'b1;
                end else begin
                    done_s = 1'b0;
                    err_s  = 1'b0;
                end
            end
            ST_VERDICT: begin
                done_s = 1'b1;
                err_s  = CHECKSUM_EN && !(csum_pass_s || (csum_rx_r == 16'h0000));
            end
            default: begin
                done_s = 1'b0;
                err_s  = 1'b0;
            end
        endcase
    end

    // Registered framing, verdict and header-drop outputs.
    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            udp_drop_r <= 1'b0;
            valid_r    <= 1'b0;
            sop_r      <= 1'b0;
            eop_r      <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            data_r     <= {DATA_W{1'b0}};
        end else begin
            udp_drop_r <= udp_drop_s;
            valid_r    <= valid_s;
            sop_r      <= sop_s;
            eop_r      <= eop_s;
            done_r     <= done_s;
            err_r      <= err_s;
            data_r     <= valid_s ? i_segment_data : data_r;
        end
    end

    // Header field capture and payload byte counting.
    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            hdr_cnt_r     <= 3'd0;
            pay_cnt_r     <= 16'd0;
            payload_len_r <= 16'd0;
            udp_len_r     <= 16'd0;
            csum_rx_r     <= 16'd0;
            src_port_r    <= 16'd0;
            src_ip_r      <= 32'd0;
            prev_byte_r   <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_udp_s) begin
                        src_ip_r    <= i_src_ip;
                        prev_byte_r <= i_segment_data;
                        hdr_cnt_r   <= 3'd1;
                    end
                end
                ST_HEADER: begin
                    if (hdr_byte_s) begin
                        prev_byte_r <= i_segment_data;
                        hdr_cnt_r   <= hdr_cnt_r + 3'd1;
                        case (hdr_cnt_r)
                            3'd1: src_port_r <= word_s;
                            3'd5: begin
                                udp_len_r <= word_s;
                                if (!hdr_reject_s) begin
                                    payload_len_r <= word_s - UDP_HDR_LEN;
                                end
                            end
                            3'd7: begin
                                csum_rx_r <= word_s;
                                pay_cnt_r <= 16'd0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                ST_PAYLOAD: begin
                    if (pay_byte_s) begin
                        pay_cnt_r <= pay_cnt_r + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_udp_drop       = udp_drop_r;
    assign pl.src_ip        = src_ip_r;
    assign pl.src_port      = src_port_r;
    assign pl.payload_len   = payload_len_r;
    assign pl.payload_valid = valid_r;
    assign pl.payload_sop   = sop_r;
    assign pl.payload_eop   = eop_r;
    assign pl.payload_data  = data_r;
    assign pl.payload_done  = done_r;
    assign pl.payload_err   = err_r;
endmodule
